// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB slave front-end for a single-word-per-access SRAM.
//   Converts each APB transfer into at most one single-cycle mem_rd/mem_wr
//   strobe, inserts WAIT_STATES extra access cycles, and reports misaligned
//   or out-of-range accesses through pslverr.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata, pstrb  APB byte address, write data, write strobes
//   prdata, pready,       APB read data / completion / error (valid in DONE)
//   pslverr
//   mem_wr, mem_rd        single-cycle memory strobes
//   mem_be, mem_address,  latched byte enables, word address, write data
//   mem_data_in
//   mem_data_out          combinational read data from memory
module apb_mem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_SIZE    = 256,
  parameter int unsigned AW          = $clog2(MEM_SIZE),
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [3:0]            pstrb,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [3:0]            mem_be,
  output logic [AW-1:0]         mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned WADR_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q,  state_d;
  logic [CNT_W-1:0]      cnt_q,    cnt_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] wdata_q,  wdata_d;
  logic [BE_W-1:0]       be_q,     be_d;
  logic [AW-1:0]         addr_q,   addr_d;
  logic                  err_q,    err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

  logic setup_c;
  logic access_c;
  logic addr_err_c;

  // Setup phase of a new transfer, only recognised from IDLE
  assign setup_c = (state_q == ST_IDLE) && psel && !penable;

  // The single access cycle: last wait cycle with the master still selecting us
  assign access_c = (state_q == ST_WAIT) && (cnt_q == CNT_W'(0)) && psel;

  // Misaligned byte address or word index beyond the memory depth
  assign addr_err_c = (paddr[1:0] != 2'b00) ||
                      (paddr[ADDR_WIDTH-1:2] >= WADR_W'(MEM_SIZE));

  // State and transfer registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pwrite_q <= 1'b0;
      wdata_q  <= '0;
      be_q     <= '0;
      addr_q   <= '0;
      err_q    <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pwrite_q <= pwrite_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  // Next-state and register update logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pwrite_d = pwrite_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    addr_d   = addr_q;
    err_d    = err_q;
    prdata_d = prdata_q;

    unique case (state_q)
      ST_IDLE: begin
        if (setup_c) begin
          pwrite_d = pwrite;
          wdata_d  = pwdata;
          // Reads always enable all lanes; writes use the APB strobes
          be_d     = pwrite ? pstrb : BE_W'(4'hF);
          addr_d   = paddr[AW+1:2];
          err_d    = addr_err_c;
          cnt_d    = CNT_W'(WAIT_STATES);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_q != CNT_W'(0)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          // Read data is only meaningful for a good read; otherwise return 0
          prdata_d = (!pwrite_q && !err_q) ? mem_data_out : '0;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Memory strobes; a write with no enabled lanes issues no strobe at all
  assign mem_wr = access_c &&  pwrite_q && !err_q && (be_q != BE_W'(0));
  assign mem_rd = access_c && !pwrite_q && !err_q;

  // Memory side address/data/lanes come straight from the latched registers
  assign mem_be      = be_q;
  assign mem_address = addr_q;
  assign mem_data_in = wdata_q;

  // APB response, only driven in DONE
  assign pready  = (state_q == ST_DONE);
  assign pslverr = (state_q == ST_DONE) && err_q;
  assign prdata  = (state_q == ST_DONE) ? prdata_q : '0;

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Testbench for apb_mem_ctrl: two instances (0 and 3 wait states) share one
// APB bus, each with its own SRAM model. Each transfer runs a fixed 7-cycle
// window; the expected per-cycle timeline is computed from the transfer rules.
module tb_apb_mem_ctrl;

  localparam int unsigned NCYC = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;
  logic        clr;

  logic [31:0] prdata0, mdo0, mdi0, prdata3, mdo3, mdi3;
  logic        pready0, pslverr0, mwr0, mrd0, pready3, pslverr3, mwr3, mrd3;
  logic [3:0]  mbe0, mbe3;
  logic [7:0]  madr0, madr3;

  apb_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata0),
    .pready(pready0), .pslverr(pslverr0), .mem_wr(mwr0), .mem_rd(mrd0),
    .mem_be(mbe0), .mem_address(madr0), .mem_data_in(mdi0), .mem_data_out(mdo0)
  );

  apb_mem_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_SIZE(256), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata3),
    .pready(pready3), .pslverr(pslverr3), .mem_wr(mwr3), .mem_rd(mrd3),
    .mem_be(mbe3), .mem_address(madr3), .mem_data_in(mdi3), .mem_data_out(mdo3)
  );

  // SRAM models: combinational read, byte-enabled write at the clock edge
  logic [31:0] sram0 [256];
  logic [31:0] sram3 [256];
  assign mdo0 = sram0[madr0];
  assign mdo3 = sram3[madr3];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) sram0[i] <= 32'h0;
    end else if (mwr0) begin
      for (int b = 0; b < 4; b++) if (mbe0[b]) sram0[madr0][8*b +: 8] <= mdi0[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) sram3[i] <= 32'h0;
    end else if (mwr3) begin
      for (int b = 0; b < 4; b++) if (mbe3[b]) sram3[madr3][8*b +: 8] <= mdi3[8*b +: 8];
    end
  end

  // Reference memory contents per instance
  logic [31:0] ref_mem [2][256];

  // Per-cycle captures per instance: {mem_wr, mem_rd, pready, pslverr}
  logic [3:0]  cap_f   [2][NCYC];
  logic [31:0] cap_p   [2][NCYC];
  logic [3:0]  cap_be  [2][NCYC];
  logic [7:0]  cap_adr [2][NCYC];
  logic [31:0] cap_din [2][NCYC];

  int checks;
  int errors;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_idle(input string nm);
    chk({nm, " dut0"}, {mwr0, mrd0, pready0, pslverr0, prdata0, mbe0, madr0, mdi0}, 96'h0);
    chk({nm, " dut3"}, {mwr3, mrd3, pready3, pslverr3, prdata3, mbe3, madr3, mdi3}, 96'h0);
  endtask

  // Drive one transfer over a 7-cycle window. ab: first cycle with psel=0
  // (0 = no abort). rs: cycle during which rst_n is low (0 = none).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int ab, input int rs);
    for (int k = 0; k < int'(NCYC); k++) begin
      if (k == 0) begin
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
      end else begin
        penable = 1'b1;
      end
      if (ab != 0 && k >= ab) psel = 1'b0;
      if (k == int'(NCYC) - 1) begin psel = 1'b0; penable = 1'b0; end
      rst_n = (rs != 0 && k == rs) ? 1'b0 : 1'b1;
      @(negedge clk);
      cap_f[0][k] = {mwr0, mrd0, pready0, pslverr0};
      cap_p[0][k] = prdata0; cap_be[0][k] = mbe0; cap_adr[0][k] = madr0; cap_din[0][k] = mdi0;
      cap_f[1][k] = {mwr3, mrd3, pready3, pslverr3};
      cap_p[1][k] = prdata3; cap_be[1][k] = mbe3; cap_adr[1][k] = madr3; cap_din[1][k] = mdi3;
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    psel  = 1'b0;
  endtask

  // Compare one instance's captured window against the transfer timeline
  task automatic check_dut(input int sel, input int ws, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s, input int ab, input int rs,
                           output logic [31:0] rd_obs, output logic err_obs);
    logic        aerr, alive_s, alive_d, strobe;
    logic [7:0]  idx;
    logic [31:0] erd, ep;
    logic [3:0]  ef;
    int          st, dn;
    string       nm;
    aerr    = (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    idx     = a[9:2];
    st      = 1 + ws;
    dn      = 2 + ws;
    alive_s = (ab == 0 || ab > st) && (rs == 0 || st <= rs);
    alive_d = alive_s && (rs == 0 || dn <= rs);
    strobe  = alive_s && !aerr && (!w || s != 4'h0);
    erd     = (alive_d && !w && !aerr) ? ref_mem[sel][idx] : 32'h0;
    for (int k = 0; k < int'(NCYC); k++) begin
      ef = {strobe && w && (k == st), strobe && !w && (k == st),
            alive_d && (k == dn), alive_d && aerr && (k == dn)};
      ep = (k == dn) ? erd : 32'h0;
      nm = $sformatf("ws%0d a=%0h cyc%0d wr/rd/rdy/err/prdata", ws, a, k);
      chk(nm, {60'h0, cap_f[sel][k], cap_p[sel][k]}, {60'h0, ef, ep});
    end
    if (strobe) begin
      chk($sformatf("ws%0d a=%0h mem_address", ws, a), {88'h0, cap_adr[sel][st]}, {88'h0, idx});
      chk($sformatf("ws%0d a=%0h mem_be", ws, a), {92'h0, cap_be[sel][st]},
          {92'h0, (w ? s : 4'hF)});
      if (w) begin
        chk($sformatf("ws%0d a=%0h mem_data_in", ws, a), {64'h0, cap_din[sel][st]}, {64'h0, d});
        for (int b = 0; b < 4; b++) if (s[b]) ref_mem[sel][idx][8*b +: 8] = d[8*b +: 8];
      end
    end
    rd_obs  = cap_p[sel][dn];
    err_obs = cap_f[sel][dn][0];
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    int          ab;
    int          rs;
    logic        err;
    logic        chk_rd;
    logic [31:0] rd0;
    logic [31:0] rd3;
  } vec_t;

  localparam int NV = 14;
  vec_t vt [NV];

  initial begin
    logic [31:0] r0, r3, ra, rdv;
    logic        e0, e3, rw;
    logic [3:0]  rsb;
    int          rab, sel_addr;

    vt[0]  = '{1'b1, 32'h010, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[1]  = '{1'b0, 32'h010, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 32'h010, 32'h0000AA00, 4'h2, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[3]  = '{1'b0, 32'h010, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'hDEADAAEF, 32'hDEADAAEF};
    vt[4]  = '{1'b0, 32'h400, 32'h0,        4'h0, 0, 0, 1'b1, 1'b1, 32'h0,        32'h0};
    vt[5]  = '{1'b1, 32'h013, 32'h11223344, 4'hF, 0, 0, 1'b1, 1'b0, 32'h0,        32'h0};
    vt[6]  = '{1'b0, 32'h3FC, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'h0,        32'h0};
    vt[7]  = '{1'b1, 32'h020, 32'h12345678, 4'h0, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[8]  = '{1'b0, 32'h020, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'h0,        32'h0};
    vt[9]  = '{1'b1, 32'h024, 32'hCAFEF00D, 4'hF, 2, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[10] = '{1'b0, 32'h024, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'hCAFEF00D, 32'h0};
    vt[11] = '{1'b0, 32'h010, 32'h0,        4'h0, 0, 3, 1'b0, 1'b1, 32'hDEADAAEF, 32'h0};
    vt[12] = '{1'b1, 32'h3FC, 32'h55AA55AA, 4'hF, 0, 0, 1'b0, 1'b0, 32'h0,        32'h0};
    vt[13] = '{1'b0, 32'h3FC, 32'h0,        4'h0, 0, 0, 1'b0, 1'b1, 32'h55AA55AA, 32'h55AA55AA};

    checks = 0;
    errors = 0;
    for (int i = 0; i < 256; i++) begin ref_mem[0][i] = 32'h0; ref_mem[1][i] = 32'h0; end

    // Reset held with an APB bus that looks mid-transfer
    clr = 1'b1; rst_n = 1'b0;
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
    paddr = 32'h10; pwdata = 32'hDEADBEEF; pstrb = 4'hF;
    @(posedge clk); #1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_idle($sformatf("reset cyc%0d", c));
      @(posedge clk); #1;
    end
    rst_n = 1'b1; clr = 1'b0;
    @(negedge clk);
    check_idle("after reset, no setup");
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      xfer(vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].ab, vt[i].rs);
      check_dut(0, 0, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].ab, vt[i].rs, r0, e0);
      check_dut(1, 3, vt[i].w, vt[i].a, vt[i].d, vt[i].s, vt[i].ab, vt[i].rs, r3, e3);
      chk($sformatf("vec%0d pslverr ws0", i), {95'h0, e0}, {95'h0, vt[i].err});
      chk($sformatf("vec%0d pslverr ws3", i), {95'h0, e3}, {95'h0, vt[i].err});
      if (vt[i].chk_rd) begin
        chk($sformatf("vec%0d prdata ws0", i), {64'h0, r0}, {64'h0, vt[i].rd0});
        chk($sformatf("vec%0d prdata ws3", i), {64'h0, r3}, {64'h0, vt[i].rd3});
      end
    end

    // Randomized transfers against the reference timeline and memory
    for (int n = 0; n < 80; n++) begin
      sel_addr = int'($urandom_range(0, 9));
      if (sel_addr < 7)       ra = 32'($urandom_range(0, 31)) << 2;
      else if (sel_addr == 7) ra = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
      else if (sel_addr == 8) ra = 32'h400 + (32'($urandom_range(0, 1023)) << 2);
      else                    ra = 32'h3FC;
      rw  = 1'($urandom_range(0, 1));
      rdv = $urandom;
      rsb = 4'($urandom_range(0, 15));
      rab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      xfer(rw, ra, rdv, rsb, rab, 0);
      check_dut(0, 0, rw, ra, rdv, rsb, rab, 0, r0, e0);
      check_dut(1, 3, rw, ra, rdv, rsb, rab, 0, r3, e3);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
